// File: rtl/ibex_pkg.sv
// ibex_pkg
// Shared types for the ID-side execute issue controller.
//   rv32m_e          : M-extension implementation variant
//   ex_op_class_e    : how an instruction occupies EX (single cycle, multi-cycle
//                      ALU, multiplier, divider)
//   ex_issue_state_e : issue-controller FSM states
//   IMD_N / IMD_W    : count and width of the intermediate-value words
package ibex_pkg;

    typedef enum integer {
        RV32MNone        = 0,
        RV32MSlow        = 1,
        RV32MFast        = 2,
        RV32MSingleCycle = 3
    } rv32m_e;

    typedef enum logic [1:0] {
        OP_SINGLE    = 2'd0,
        OP_ALU_MULTI = 2'd1,
        OP_MULT      = 2'd2,
        OP_DIV       = 2'd3
    } ex_op_class_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MULTI   = 2'd1,
        WAIT_WB = 2'd2
    } ex_issue_state_e;

    localparam int unsigned IMD_N = 2;
    localparam int unsigned IMD_W = 34;

endpackage

// File: rtl/ibex_ex_issue_ctrl_imd_val_regs.sv
// ibex_imd_val_regs
// Two 34-bit intermediate-value registers shared between ID and EX. Each word
// has its own write enable; both words may be written in the same cycle.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset (clears to zero)
//   we_i         : per-word write enable
//   d_i          : per-word write data
//   q_o          : registered per-word values
module ibex_imd_val_regs
    import ibex_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [IMD_N-1:0]            we_i,
    input  logic [IMD_N-1:0][IMD_W-1:0] d_i,
    output logic [IMD_N-1:0][IMD_W-1:0] q_o
);

    genvar gi;
    generate
        for (gi = 0; gi < IMD_N; gi++) begin : g_word
            logic [IMD_W-1:0] q_reg;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    q_reg <= '0;
                end else if (we_i[gi]) begin
                    q_reg <= d_i[gi];
                end
            end

            assign q_o[gi] = q_reg;
        end
    endgenerate

endmodule

// File: rtl/ibex_ex_issue_ctrl.sv
// ibex_ex_issue_ctrl
// ID-side issue control for the execute block's multi-cycle protocol. Issues
// ALU / multiplier / divider operations, drives the dynamic enables, static
// selects and first-cycle flag, owns the intermediate-value registers, holds
// ID until EX has a result that writeback accepts, and counts stall cycles.
// Ports:
//   clk_i, rst_i             : clock, synchronous active-high reset
//   instr_valid_i            : decoded instruction present in ID
//   op_class_i               : ex_op_class_e of that instruction
//   flush_i                  : kill the current instruction
//   wb_ready_i               : writeback accepts a result this cycle
//   ex_valid_i               : EX output is valid
//   imd_val_we_i/_d_i        : intermediate-value write enable / data from EX
//   imd_val_q_o              : intermediate values to EX
//   alu_instr_first_cycle_o  : first EX cycle of the current instruction
//   mult_en_o / div_en_o     : dynamic enables (low while waiting on writeback)
//   mult_sel_o / div_sel_o   : static selects
//   multdiv_ready_id_o       : ID can take a mult/div result
//   instr_done_o             : instruction retires from EX this cycle
//   busy_o                   : controller not idle
//   stall_cnt_o              : saturating stall-cycle count
module ibex_ex_issue_ctrl
    import ibex_pkg::*;
#(
    parameter rv32m_e      RV32M     = ibex_pkg::RV32MFast,
    parameter int unsigned StallCntW = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        instr_valid_i,
    input  logic [1:0]                  op_class_i,
    input  logic                        flush_i,
    input  logic                        wb_ready_i,
    input  logic                        ex_valid_i,
    input  logic [IMD_N-1:0]            imd_val_we_i,
    input  logic [IMD_N-1:0][IMD_W-1:0] imd_val_d_i,
    output logic [IMD_N-1:0][IMD_W-1:0] imd_val_q_o,
    output logic                        alu_instr_first_cycle_o,
    output logic                        mult_en_o,
    output logic                        div_en_o,
    output logic                        mult_sel_o,
    output logic                        div_sel_o,
    output logic                        multdiv_ready_id_o,
    output logic                        instr_done_o,
    output logic                        busy_o,
    output logic [StallCntW-1:0]        stall_cnt_o
);

    localparam bit MExtEn = (RV32M != RV32MNone);

    ex_issue_state_e      state_reg, state_next;
    ex_op_class_e         op_class, op_class_eff;
    logic                 act;
    logic [IMD_N-1:0]     imd_we;
    logic [StallCntW-1:0] stall_cnt_reg;

    assign op_class = ex_op_class_e'(op_class_i);

    // Without the M extension, mult/div still occupy EX for several cycles,
    // so they are steered through the generic multi-cycle ALU path.
    always_comb begin
        op_class_eff = op_class;
        if (!MExtEn && (op_class == OP_MULT || op_class == OP_DIV)) begin
            op_class_eff = OP_ALU_MULTI;
        end
    end

    // A flushed or absent instruction is invisible to EX.
    assign act = instr_valid_i & ~flush_i;

    assign mult_sel_o              = act & (op_class_eff == OP_MULT);
    assign div_sel_o               = act & (op_class_eff == OP_DIV);
    // EX holds its result while writeback stalls, so it must not step again.
    assign mult_en_o               = mult_sel_o & (state_reg != WAIT_WB);
    assign div_en_o                = div_sel_o & (state_reg != WAIT_WB);
    assign alu_instr_first_cycle_o = act & (state_reg == IDLE);
    assign multdiv_ready_id_o      = wb_ready_i;
    assign instr_done_o            = act & ex_valid_i & wb_ready_i;
    assign busy_o                  = (state_reg != IDLE);
    assign stall_cnt_o             = stall_cnt_reg;

    always_comb begin
        state_next = state_reg;
        if (!act) begin
            state_next = IDLE;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (ex_valid_i) begin
                        state_next = wb_ready_i ? IDLE : WAIT_WB;
                    end else if (op_class_eff != OP_SINGLE) begin
                        state_next = MULTI;
                    end else begin
                        state_next = IDLE;
                    end
                end
                MULTI: begin
                    if (ex_valid_i) begin
                        state_next = wb_ready_i ? IDLE : WAIT_WB;
                    end else begin
                        state_next = MULTI;
                    end
                end
                WAIT_WB: begin
                    state_next = wb_ready_i ? IDLE : WAIT_WB;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Saturating stall counter: never wraps back to a small value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_reg <= '0;
        end else if (act && !instr_done_o && !(&stall_cnt_reg)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    // Writes from EX are ignored while its result is parked for writeback.
    assign imd_we = imd_val_we_i & {IMD_N{act & (state_reg != WAIT_WB)}};

    ibex_imd_val_regs u_imd_val_regs (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .we_i  (imd_we),
        .d_i   (imd_val_d_i),
        .q_o   (imd_val_q_o)
    );

    // A single-cycle op must produce its result in the cycle it is issued.
    a_single_completes: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_reg == IDLE && act && !ex_valid_i) |-> (op_class_eff != OP_SINGLE));

    // Dropping instr_valid_i mid-instruction acts as a flush but is unexpected.
    a_valid_held: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_reg != IDLE) |-> instr_valid_i);

endmodule

// File: tb/tb_ibex_ex_issue_ctrl.sv
module tb_ibex_ex_issue_ctrl;
    import ibex_pkg::*;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             instr_valid;
    logic [1:0]       op_class;
    logic             flush;
    logic             wb_ready;
    logic             ex_valid;
    logic [1:0]       imd_we;
    logic [1:0][33:0] imd_d;

    // main instance (RV32MFast, 16-bit counter)
    logic [1:0][33:0] m_q;
    logic m_first, m_men, m_den, m_msel, m_dsel, m_rdy, m_done, m_busy;
    logic [15:0] m_stall;
    // 4-bit counter instance
    logic [1:0][33:0] s_q;
    logic s_first, s_men, s_den, s_msel, s_dsel, s_rdy, s_done, s_busy;
    logic [3:0] s_stall;
    // no M extension instance
    logic [1:0][33:0] n_q;
    logic n_first, n_men, n_den, n_msel, n_dsel, n_rdy, n_done, n_busy;
    logic [15:0] n_stall;

    // {first_cycle, mult_sel, mult_en, div_sel, div_en, instr_done}
    logic [5:0] m_ctl, n_ctl;
    assign m_ctl = {m_first, m_msel, m_men, m_dsel, m_den, m_done};
    assign n_ctl = {n_first, n_msel, n_men, n_dsel, n_den, n_done};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    ibex_ex_issue_ctrl u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_valid_i(instr_valid), .op_class_i(op_class),
        .flush_i(flush), .wb_ready_i(wb_ready), .ex_valid_i(ex_valid),
        .imd_val_we_i(imd_we), .imd_val_d_i(imd_d), .imd_val_q_o(m_q),
        .alu_instr_first_cycle_o(m_first), .mult_en_o(m_men), .div_en_o(m_den),
        .mult_sel_o(m_msel), .div_sel_o(m_dsel), .multdiv_ready_id_o(m_rdy),
        .instr_done_o(m_done), .busy_o(m_busy), .stall_cnt_o(m_stall)
    );

    ibex_ex_issue_ctrl #(.StallCntW(4)) u_sat (
        .clk_i(clk_i), .rst_i(rst_i), .instr_valid_i(instr_valid), .op_class_i(op_class),
        .flush_i(flush), .wb_ready_i(wb_ready), .ex_valid_i(ex_valid),
        .imd_val_we_i(imd_we), .imd_val_d_i(imd_d), .imd_val_q_o(s_q),
        .alu_instr_first_cycle_o(s_first), .mult_en_o(s_men), .div_en_o(s_den),
        .mult_sel_o(s_msel), .div_sel_o(s_dsel), .multdiv_ready_id_o(s_rdy),
        .instr_done_o(s_done), .busy_o(s_busy), .stall_cnt_o(s_stall)
    );

    ibex_ex_issue_ctrl #(.RV32M(ibex_pkg::RV32MNone)) u_none (
        .clk_i(clk_i), .rst_i(rst_i), .instr_valid_i(instr_valid), .op_class_i(op_class),
        .flush_i(flush), .wb_ready_i(wb_ready), .ex_valid_i(ex_valid),
        .imd_val_we_i(imd_we), .imd_val_d_i(imd_d), .imd_val_q_o(n_q),
        .alu_instr_first_cycle_o(n_first), .mult_en_o(n_men), .div_en_o(n_den),
        .mult_sel_o(n_msel), .div_sel_o(n_dsel), .multdiv_ready_id_o(n_rdy),
        .instr_done_o(n_done), .busy_o(n_busy), .stall_cnt_o(n_stall)
    );

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] cls, input logic fl,
                         input logic ev, input logic wb, input logic [1:0] we,
                         input logic [33:0] d0, input logic [33:0] d1);
        instr_valid = v;
        op_class    = cls;
        flush       = fl;
        ex_valid    = ev;
        wb_ready    = wb;
        imd_we      = we;
        imd_d[0]    = d0;
        imd_d[1]    = d1;
    endtask

    task automatic drive_idle;
        drive(1'b0, OP_SINGLE, 1'b0, 1'b0, 1'b0, 2'b00, 34'h0, 34'h0);
    endtask

    task automatic do_reset;
        rst_i = 1'b1;
        drive_idle();
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset;
        // put the DUT mid-divide with written registers, then reset it
        drive(1'b1, OP_DIV, 1'b0, 1'b0, 1'b1, 2'b11, 34'h3_1234_5678, 34'h0_ABCD_0000);
        tick();
        #1;
        n_checks++;
        if (m_busy !== 1'b1) begin n_fail++; $display("FAIL reset_pre_busy: got %b want 1", m_busy); end
        n_checks++;
        if (m_q !== {34'h0_ABCD_0000, 34'h3_1234_5678}) begin
            n_fail++; $display("FAIL reset_pre_q: got %h want %h", m_q, {34'h0_ABCD_0000, 34'h3_1234_5678});
        end
        rst_i = 1'b1;
        drive(1'b1, OP_MULT, 1'b0, 1'b1, 1'b0, 2'b11, 34'h2_DEAD_BEEF, 34'h1_CAFE_F00D);
        tick();
        tick();
        rst_i = 1'b0;
        drive_idle();
        #1;
        n_checks++;
        if (m_q !== 68'h0) begin n_fail++; $display("FAIL reset_q: got %h want 0", m_q); end
        n_checks++;
        if (m_stall !== 16'h0) begin n_fail++; $display("FAIL reset_stall: got %0d want 0", m_stall); end
        n_checks++;
        if (m_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", m_busy); end
        n_checks++;
        if ({m_ctl, m_rdy} !== 7'b0) begin n_fail++; $display("FAIL reset_outputs: got %b want 0", {m_ctl, m_rdy}); end
        $display("test_reset: finished");
    endtask

    task automatic test_alu_single;
        drive(1'b1, OP_SINGLE, 1'b0, 1'b1, 1'b1, 2'b10, 34'h0, 34'h2_5A5A_A5A5);
        #1;
        n_checks++;
        if (m_ctl !== 6'b100001) begin n_fail++; $display("FAIL alu_ctl: got %b want 100001", m_ctl); end
        tick();
        drive_idle();
        #1;
        n_checks++;
        if (m_busy !== 1'b0) begin n_fail++; $display("FAIL alu_busy: got %b want 0", m_busy); end
        n_checks++;
        if (m_stall !== 16'd0) begin n_fail++; $display("FAIL alu_stall: got %0d want 0", m_stall); end
        n_checks++;
        if (m_q !== {34'h2_5A5A_A5A5, 34'h0}) begin
            n_fail++; $display("FAIL alu_q_word1_only: got %h want %h", m_q, {34'h2_5A5A_A5A5, 34'h0});
        end
        $display("test_alu_single: finished");
    endtask

    task automatic test_divide;
        logic [33:0] d0, d1, p0, p1;
        logic [67:0] exp_q;
        do_reset();
        p0 = 34'h0;
        p1 = 34'h0;
        for (int i = 0; i <= 36; i++) begin
            d0 = 34'h2_0000_0001 + 34'(i);
            d1 = 34'h1_FFFF_FFFF - 34'(i);
            drive(1'b1, OP_DIV, 1'b0, (i == 36), 1'b1, 2'b11, d0, d1);
            #1;
            n_checks++;
            if (m_ctl !== {(i == 0), 1'b0, 1'b0, 1'b1, 1'b1, (i == 36)}) begin
                n_fail++; $display("FAIL div_ctl cyc %0d: got %b want %b", i, m_ctl,
                                   {(i == 0), 1'b0, 1'b0, 1'b1, 1'b1, (i == 36)});
            end
            n_checks++;
            if (m_stall !== 16'(i)) begin n_fail++; $display("FAIL div_stall cyc %0d: got %0d want %0d", i, m_stall, i); end
            n_checks++;
            if (m_busy !== (i != 0)) begin n_fail++; $display("FAIL div_busy cyc %0d: got %b want %b", i, m_busy, (i != 0)); end
            exp_q = {p1, p0};
            n_checks++;
            if (m_q !== exp_q) begin n_fail++; $display("FAIL div_q cyc %0d: got %h want %h", i, m_q, exp_q); end
            p0 = d0;
            p1 = d1;
            tick();
        end
        drive_idle();
        #1;
        n_checks++;
        if (m_stall !== 16'd36) begin n_fail++; $display("FAIL div_stall_end: got %0d want 36", m_stall); end
        n_checks++;
        if (m_busy !== 1'b0) begin n_fail++; $display("FAIL div_busy_end: got %b want 0", m_busy); end
        n_checks++;
        if (m_q !== {34'h1_FFFF_FFDB, 34'h2_0000_0025}) begin
            n_fail++; $display("FAIL div_q_end: got %h want %h", m_q, {34'h1_FFFF_FFDB, 34'h2_0000_0025});
        end
        $display("test_divide: finished");
    endtask

    task automatic test_backpressure;
        do_reset();
        drive(1'b1, OP_MULT, 1'b0, 1'b1, 1'b0, 2'b11, 34'h1_1111_1111, 34'h2_2222_2222);
        #1;
        n_checks++;
        if (m_ctl !== 6'b111000) begin n_fail++; $display("FAIL bp_ctl0: got %b want 111000", m_ctl); end
        tick();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, OP_MULT, 1'b0, 1'b1, (i == 3), 2'b11, 34'h3_3333_3333, 34'h0_4444_4444);
            #1;
            n_checks++;
            if (m_ctl !== {5'b01000, (i == 3)}) begin
                n_fail++; $display("FAIL bp_ctl cyc %0d: got %b want %b", i, m_ctl, {5'b01000, (i == 3)});
            end
            n_checks++;
            if (m_rdy !== (i == 3)) begin n_fail++; $display("FAIL bp_ready cyc %0d: got %b want %b", i, m_rdy, (i == 3)); end
            n_checks++;
            if (m_busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy cyc %0d: got %b want 1", i, m_busy); end
            tick();
            #1;
            n_checks++;
            if (m_q !== {34'h2_2222_2222, 34'h1_1111_1111}) begin
                n_fail++; $display("FAIL bp_q_frozen cyc %0d: got %h want %h", i, m_q, {34'h2_2222_2222, 34'h1_1111_1111});
            end
        end
        drive_idle();
        #1;
        n_checks++;
        if (m_busy !== 1'b0) begin n_fail++; $display("FAIL bp_busy_end: got %b want 0", m_busy); end
        n_checks++;
        if (m_stall !== 16'd3) begin n_fail++; $display("FAIL bp_stall_end: got %0d want 3", m_stall); end
        $display("test_backpressure: finished");
    endtask

    task automatic test_flush;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, OP_MULT, 1'b0, 1'b0, 1'b1, 2'b00, 34'h0, 34'h0);
            #1;
            n_checks++;
            if (m_ctl !== {(i == 0), 5'b11000}) begin
                n_fail++; $display("FAIL flush_pre_ctl cyc %0d: got %b want %b", i, m_ctl, {(i == 0), 5'b11000});
            end
            tick();
        end
        drive(1'b1, OP_MULT, 1'b1, 1'b1, 1'b1, 2'b01, 34'h3_FFFF_0000, 34'h0);
        #1;
        n_checks++;
        if (m_ctl !== 6'b000000) begin n_fail++; $display("FAIL flush_ctl: got %b want 000000", m_ctl); end
        tick();
        drive(1'b1, OP_SINGLE, 1'b0, 1'b1, 1'b1, 2'b00, 34'h0, 34'h0);
        #1;
        n_checks++;
        if (m_busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", m_busy); end
        n_checks++;
        if (m_q !== 68'h0) begin n_fail++; $display("FAIL flush_q: got %h want 0", m_q); end
        n_checks++;
        if (m_ctl !== 6'b100001) begin n_fail++; $display("FAIL flush_next_ctl: got %b want 100001", m_ctl); end
        n_checks++;
        if (m_stall !== 16'd2) begin n_fail++; $display("FAIL flush_stall: got %0d want 2", m_stall); end
        tick();
        drive_idle();
        #1;
        n_checks++;
        if (m_stall !== 16'd2) begin n_fail++; $display("FAIL flush_stall_end: got %0d want 2", m_stall); end
        $display("test_flush: finished");
    endtask

    task automatic test_saturation;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, OP_DIV, 1'b0, 1'b0, 1'b1, 2'b00, 34'h0, 34'h0);
            #1;
            n_checks++;
            if (s_stall !== ((i < 15) ? 4'(i) : 4'hF)) begin
                n_fail++; $display("FAIL sat_stall cyc %0d: got %h want %h", i, s_stall, ((i < 15) ? 4'(i) : 4'hF));
            end
            tick();
        end
        #1;
        n_checks++;
        if (s_stall !== 4'hF) begin n_fail++; $display("FAIL sat_hold: got %h want f", s_stall); end
        n_checks++;
        if (m_stall !== 16'd20) begin n_fail++; $display("FAIL sat_wide_stall: got %0d want 20", m_stall); end
        drive(1'b1, OP_DIV, 1'b1, 1'b0, 1'b1, 2'b00, 34'h0, 34'h0);
        tick();
        drive_idle();
        #1;
        n_checks++;
        if (s_busy !== 1'b0) begin n_fail++; $display("FAIL sat_busy_end: got %b want 0", s_busy); end
        $display("test_saturation: finished");
    endtask

    task automatic test_no_mext;
        do_reset();
        drive(1'b1, OP_MULT, 1'b0, 1'b0, 1'b1, 2'b00, 34'h0, 34'h0);
        #1;
        n_checks++;
        if (n_ctl !== 6'b100000) begin n_fail++; $display("FAIL nomext_mult_ctl: got %b want 100000", n_ctl); end
        n_checks++;
        if (m_ctl !== 6'b111000) begin n_fail++; $display("FAIL mext_mult_ctl: got %b want 111000", m_ctl); end
        tick();
        drive(1'b1, OP_MULT, 1'b0, 1'b1, 1'b1, 2'b00, 34'h0, 34'h0);
        #1;
        n_checks++;
        if (n_busy !== 1'b1) begin n_fail++; $display("FAIL nomext_busy: got %b want 1", n_busy); end
        n_checks++;
        if (n_ctl !== 6'b000001) begin n_fail++; $display("FAIL nomext_done_ctl: got %b want 000001", n_ctl); end
        tick();
        drive(1'b1, OP_DIV, 1'b0, 1'b1, 1'b1, 2'b00, 34'h0, 34'h0);
        #1;
        n_checks++;
        if (n_ctl !== 6'b100001) begin n_fail++; $display("FAIL nomext_div_ctl: got %b want 100001", n_ctl); end
        n_checks++;
        if (m_ctl !== 6'b100111) begin n_fail++; $display("FAIL mext_div_ctl: got %b want 100111", m_ctl); end
        tick();
        drive_idle();
        $display("test_no_mext: finished");
    endtask

    initial begin
        rst_i = 1'b1;
        drive_idle();
        tick();
        tick();
        rst_i = 1'b0;
        test_reset();
        test_alu_single();
        test_divide();
        test_backpressure();
        test_flush();
        test_saturation();
        test_no_mext();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ibex_ex_issue_ctrl.md
Name: ibex_ex_issue_ctrl

Overview:
ID-side counterpart of the execute block's multi-cycle protocol. It issues ALU, multiplier and divider operations to EX and drives the dynamic enables, static selects and first-cycle flag. It owns the two 34-bit intermediate-value registers that EX reads and writes, holds ID until EX reports a valid result and writeback accepts it, and counts stall cycles for performance monitoring.

Parameters:
RV32M, ibex_pkg::RV32MFast, M-extension variant; RV32MNone disables all mult/div issue.
StallCntW, 16, width of the saturating stall-cycle counter.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock; reset is synchronous and active-high
instr_valid_i  in  1  decoded instruction present in ID
op_class_i  in  2  ex_op_class_e: OP_SINGLE, OP_ALU_MULTI, OP_MULT, OP_DIV
flush_i  in  1  kill current instruction (exception/debug/branch)
wb_ready_i  in  1  writeback can accept a result this cycle
ex_valid_i  in  1  EX has a valid output
imd_val_we_i  in  2  per-word write enable from EX
imd_val_d_i  in  2x34  write data from EX
imd_val_q_o  out  2x34  registered intermediate values to EX
alu_instr_first_cycle_o  out  1  first EX cycle of the current instruction
mult_en_o  out  1  dynamic multiplier enable
div_en_o  out  1  dynamic divider enable
mult_sel_o  out  1  static multiplier select
div_sel_o  out  1  static divider select
multdiv_ready_id_o  out  1  ID ready to take a mult/div result
instr_done_o  out  1  instruction retires from EX this cycle
busy_o  out  1  state != IDLE
stall_cnt_o  out  StallCntW  saturating stall-cycle count

Behaviour:
- FSM states: IDLE, MULTI (multi-cycle op in flight), WAIT_WB (EX result valid, writeback not ready). Reset state is IDLE.
- Define act = instr_valid_i & ~flush_i.
- Static selects: mult_sel_o = act & class==OP_MULT; div_sel_o = act & class==OP_DIV.
- Dynamic enables: mult_en_o = mult_sel_o & state!=WAIT_WB; div_en_o likewise.
- alu_instr_first_cycle_o = act & state==IDLE.
- multdiv_ready_id_o = wb_ready_i.
- instr_done_o = act & ex_valid_i & wb_ready_i.
- IDLE transitions:
  - act & ex_valid_i & wb_ready_i -> IDLE (done).
  - act & ex_valid_i & ~wb_ready_i -> WAIT_WB.
  - act & ~ex_valid_i & class!=OP_SINGLE -> MULTI.
  - OP_SINGLE with ~ex_valid_i is a protocol error (assertion); stay IDLE.
- MULTI: ex_valid_i & wb_ready_i -> IDLE; ex_valid_i & ~wb_ready_i -> WAIT_WB; otherwise stay.
- WAIT_WB: enables are low and EX holds its result. wb_ready_i -> IDLE with instr_done_o=1.
- flush_i in any state: next state IDLE. All enables and selects are low that cycle, instr_done_o=0, imd registers are not written.
- instr_valid_i low while state!=IDLE: treated as flush; an assertion flags it.
- Intermediate-value registers:
  - imd_val_q_o[k] <= imd_val_d_i[k] when imd_val_we_i[k] & act & state!=WAIT_WB.
  - Each word has an independent enable; both may write in the same cycle.
  - Values persist across instructions.
  - Reset value is 34'h0.
- stall_cnt_o:
  - Increments when instr_valid_i & ~flush_i & ~instr_done_o.
  - Saturates at all-ones and never wraps.
  - Reset value is 0.
- RV32M==RV32MNone: mult_sel_o, div_sel_o, mult_en_o and div_en_o are tied 0. OP_MULT and OP_DIV are handled as OP_ALU_MULTI.
- Reset mid-operation: state returns to IDLE, registers are cleared, and all outputs are low in the cycle after rst_i. Combinational outputs are 0 while instr_valid_i=0.
- Latency:
  - Single-cycle op: done in its issue cycle.
  - Multi-cycle op: done in the first cycle where ex_valid_i & wb_ready_i.
  - No extra cycles are inserted.

Decomposition:
- ibex_pkg gains ex_op_class_e (2-bit) and ex_issue_state_e (IDLE, MULTI, WAIT_WB).
- Sub-module ibex_imd_val_regs: 2x34 register file with per-word write enable and synchronous active-high reset.
- FSM and counter stay in the top module.

Test Plan:
- Reset: rst_i=1 for 2 cycles with garbage inputs -> imd_val_q_o={0,0}, stall_cnt_o=0, busy_o=0; all outputs low while instr_valid_i=0.
- ALU single-cycle: OP_SINGLE, ex_valid_i=1, wb_ready_i=1 -> alu_instr_first_cycle_o=1, instr_done_o=1 same cycle, state stays IDLE, stall_cnt_o unchanged.
- Divide, 37 cycles: OP_DIV, ex_valid_i low 36 cycles then high, imd_val_we_i=2'b11 with d=34'h2_0000_0001/34'h1_FFFF_FFFF -> div_en_o=1 throughout, first_cycle only in cycle 0, imd_val_q_o tracks writes one cycle later, stall_cnt_o=36.
- Writeback backpressure: OP_MULT, ex_valid_i=1, wb_ready_i=0 for 3 cycles -> WAIT_WB, mult_en_o=0, mult_sel_o=1, imd regs frozen despite we=2'b11, multdiv_ready_id_o=0; wb_ready_i=1 -> instr_done_o=1, IDLE.
- Flush mid-MULTI: OP_MULT for 2 cycles, then flush_i=1 with imd_val_we_i=2'b01 -> enables and selects 0, no imd write, next state IDLE, new OP_SINGLE completes next cycle.
- Counter saturation: StallCntW=4, stall for 20 cycles -> stall_cnt_o=4'hF, holds. Separately, RV32M=RV32MNone with OP_MULT -> mult_sel_o=0, mult_en_o=0.
